// File: rtl/ws2812b_rx.sv
// ws2812b_rx: receive-side decoder for the WS2812B single-wire LED protocol.
// Samples din on clk, classifies each high pulse by width as a 0 or 1 bit,
// assembles 24-bit {G,R,B} pixels MSB-first and detects the latch gap that
// ends a frame.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   din          serial line, asynchronous to clk
//   pixel_data   last decoded pixel {G,R,B} in transmitted bit order
//   pixel_index  position of pixel_data within the frame
//   pixel_valid  one-cycle strobe: pixel_data/pixel_index are new
//   frame_done   one-cycle strobe: latch gap seen after at least one bit
//   frame_pixels complete pixels in the frame just ended (saturating)
//   overflow     with frame_done: frame carried more than NUM_PIXELS pixels
//   err          one-cycle strobe on a protocol error
//   synced       level: decoder is locked and accepting bits
module ws2812b_rx #(
    parameter int unsigned NUM_PIXELS    = 64,
    parameter int unsigned THRESH_CYCLES = 7,
    parameter int unsigned MIN_HIGH      = 2,
    parameter int unsigned MAX_HIGH      = 20,
    parameter int unsigned RESET_CYCLES  = 600
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              din,
    output logic [23:0]                       pixel_data,
    output logic [$clog2(NUM_PIXELS)-1:0]     pixel_index,
    output logic                              pixel_valid,
    output logic                              frame_done,
    output logic [$clog2(NUM_PIXELS+1)-1:0]   frame_pixels,
    output logic                              overflow,
    output logic                              err,
    output logic                              synced
);

    localparam int unsigned IDX_W  = $clog2(NUM_PIXELS);
    localparam int unsigned CNT_W  = $clog2(NUM_PIXELS + 1);
    localparam int unsigned LOW_W  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned HIGH_W = $clog2(MAX_HIGH + 1);

    localparam logic [LOW_W-1:0]  LOW_MAX  = LOW_W'(RESET_CYCLES);
    localparam logic [LOW_W-1:0]  LOW_LOCK = LOW_W'(RESET_CYCLES - 1);
    localparam logic [LOW_W-1:0]  LOW_ONE  = LOW_W'(1);
    localparam logic [HIGH_W-1:0] HIGH_MAX = HIGH_W'(MAX_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_MIN = HIGH_W'(MIN_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_ONE = HIGH_W'(THRESH_CYCLES);
    localparam logic [HIGH_W-1:0] HIGH_INC = HIGH_W'(1);
    localparam logic [CNT_W-1:0]  PIX_MAX  = CNT_W'(NUM_PIXELS);
    localparam logic [CNT_W-1:0]  PIX_INC  = CNT_W'(1);

    typedef enum logic [1:0] {StSync, StLow, StHigh} state_t;

    state_t              state;
    logic                din_meta;
    logic                din_s;
    logic [LOW_W-1:0]    low_cnt;
    logic [HIGH_W-1:0]   high_cnt;
    logic [23:0]         shift;
    logic [4:0]          bit_cnt;
    logic [CNT_W-1:0]    pix_cnt;
    logic                ovf_flag;
    logic                got_bit;   // a bit arrived since the last gap

    logic                bit_val;
    logic [23:0]         word;

    assign bit_val = (high_cnt >= HIGH_ONE);
    assign word    = {shift[22:0], bit_val};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StSync;
            din_meta     <= 1'b0;
            din_s        <= 1'b0;
            low_cnt      <= '0;
            high_cnt     <= '0;
            shift        <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            ovf_flag     <= 1'b0;
            got_bit      <= 1'b0;
            pixel_data   <= '0;
            pixel_index  <= '0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            overflow     <= 1'b0;
            err          <= 1'b0;
            synced       <= 1'b0;
        end else begin
            din_meta    <= din;
            din_s       <= din_meta;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;

            case (state)
                StSync: begin
                    if (din_s) begin
                        low_cnt <= '0;
                    end else if (low_cnt == LOW_LOCK) begin
                        // This sample completes the gap: lock with a clean frame.
                        state    <= StLow;
                        low_cnt  <= LOW_MAX;
                        synced   <= 1'b1;
                        bit_cnt  <= '0;
                        pix_cnt  <= '0;
                        ovf_flag <= 1'b0;
                        got_bit  <= 1'b0;
                    end else begin
                        low_cnt <= low_cnt + LOW_ONE;
                    end
                end

                StLow: begin
                    // Gap end is evaluated on the registered count, so it still
                    // fires if the next bit starts on this very sample.
                    if ((low_cnt == LOW_MAX) && got_bit) begin
                        frame_done   <= 1'b1;
                        frame_pixels <= pix_cnt;
                        overflow     <= ovf_flag;
                        err          <= (bit_cnt != 5'd0);
                        bit_cnt      <= '0;
                        pix_cnt      <= '0;
                        ovf_flag     <= 1'b0;
                        got_bit      <= 1'b0;
                    end
                    if (din_s) begin
                        state    <= StHigh;
                        high_cnt <= HIGH_INC;
                        low_cnt  <= '0;
                    end else if (low_cnt != LOW_MAX) begin
                        low_cnt <= low_cnt + LOW_ONE;
                    end
                end

                StHigh: begin
                    if (din_s) begin
                        if (high_cnt == HIGH_MAX) begin
                            // Over-long pulse: drop the frame and relock.
                            err      <= 1'b1;
                            synced   <= 1'b0;
                            state    <= StSync;
                            low_cnt  <= '0;
                            bit_cnt  <= '0;
                            pix_cnt  <= '0;
                            ovf_flag <= 1'b0;
                            got_bit  <= 1'b0;
                        end else begin
                            high_cnt <= high_cnt + HIGH_INC;
                        end
                    end else begin
                        state   <= StLow;
                        low_cnt <= LOW_ONE;
                        if (high_cnt >= HIGH_MIN) begin
                            shift   <= word;
                            got_bit <= 1'b1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                if (pix_cnt < PIX_MAX) begin
                                    pixel_data  <= word;
                                    pixel_index <= pix_cnt[IDX_W-1:0];
                                    pixel_valid <= 1'b1;
                                    pix_cnt     <= pix_cnt + PIX_INC;
                                end else begin
                                    ovf_flag <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end

                default: state <= StSync;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Self-checking bench for ws2812b_rx. Stimulus is a sequence of high/low
// segments; a protocol-level model predicts, per clock, which strobes and
// values must appear, and one compare process checks the DUT every cycle.
module tb_ws2812b_rx;

    localparam int NP   = 64;
    localparam int TH   = 7;
    localparam int MINH = 2;
    localparam int MAXH = 20;
    localparam int RC   = 600;
    localparam int MAXC = 100000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic [5:0]  pixel_index;
    logic        pixel_valid;
    logic        frame_done;
    logic [6:0]  frame_pixels;
    logic        overflow;
    logic        err;
    logic        synced;

    ws2812b_rx #(
        .NUM_PIXELS    (NP),
        .THRESH_CYCLES (TH),
        .MIN_HIGH      (MINH),
        .MAX_HIGH      (MAXH),
        .RESET_CYCLES  (RC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .pixel_data   (pixel_data),
        .pixel_index  (pixel_index),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .overflow     (overflow),
        .err          (err),
        .synced       (synced)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected events, indexed by the clock edge after which they are visible.
    bit          exp_pv   [MAXC];
    logic [23:0] exp_pd   [MAXC];
    logic [5:0]  exp_pi   [MAXC];
    bit          exp_fd   [MAXC];
    logic [6:0]  exp_fp   [MAXC];
    bit          exp_ov   [MAXC];
    bit          exp_err  [MAXC];
    bit          exp_son  [MAXC];
    bit          exp_soff [MAXC];

    int vectors     = 0;
    int miscompares = 0;

    // Protocol-level model state.
    bit          m_locked = 1'b0;
    int          m_lowrun = 0;
    int          m_bits   = 0;
    logic [23:0] m_sh     = '0;
    int          m_npix   = 0;
    bit          m_gotbit = 1'b0;

    // Observations captured from the DUT, used by the literal checks.
    int          n_pv = 0;
    int          n_fd = 0;
    int          n_err = 0;
    logic [23:0] cap_pd [256];
    logic [5:0]  last_pi = '0;
    logic [6:0]  last_fp = '0;
    logic        last_ov = 1'b0;
    logic        last_fd_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic clr_frame();
        m_bits   = 0;
        m_npix   = 0;
        m_gotbit = 1'b0;
    endtask

    // A high segment of h samples starting at sample k0; it is always followed
    // by low, so the decision is made on sample k0+h.
    task automatic model_high(input int k0, input int h);
        int  c;
        bit  b;
        m_lowrun = 0;
        if (!m_locked) return;
        if (h > MAXH) begin
            c = k0 + MAXH + 2;
            if (c < MAXC) begin
                exp_err[c]  = 1'b1;
                exp_soff[c] = 1'b1;
            end
            m_locked = 1'b0;
            clr_frame();
        end else if (h >= MINH) begin
            b        = (h >= TH);
            m_sh     = {m_sh[22:0], b};
            m_gotbit = 1'b1;
            m_bits++;
            if (m_bits == 24) begin
                m_bits = 0;
                if (m_npix < NP) begin
                    c = k0 + h + 2;
                    if (c < MAXC) begin
                        exp_pv[c] = 1'b1;
                        exp_pd[c] = m_sh;
                        exp_pi[c] = 6'(m_npix);
                    end
                end
                m_npix++;
            end
        end
    endtask

    task automatic model_low(input int k0, input int l);
        int c;
        if (!m_locked) begin
            if (m_lowrun + l >= RC) begin
                c = k0 + (RC - m_lowrun) - 1 + 2;
                if (c < MAXC) exp_son[c] = 1'b1;
                m_locked = 1'b1;
                clr_frame();
            end
        end else if (m_gotbit && (m_lowrun + l >= RC)) begin
            c = k0 + (RC - m_lowrun) + 2;
            if (c < MAXC) begin
                exp_fd[c]  = 1'b1;
                exp_fp[c]  = 7'((m_npix > NP) ? NP : m_npix);
                exp_ov[c]  = (m_npix > NP);
                exp_err[c] = (m_bits != 0);
            end
            clr_frame();
        end
        m_lowrun += l;
    endtask

    task automatic send_high(input int h);
        int k0;
        @(negedge clk);
        din = 1'b1;
        k0  = cyc + 1;
        model_high(k0, h);
        repeat (h - 1) @(negedge clk);
    endtask

    task automatic send_low(input int l);
        int k0;
        @(negedge clk);
        din = 1'b0;
        k0  = cyc + 1;
        model_low(k0, l);
        repeat (l - 1) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        if (b) begin
            send_high(10);
            send_low(5);
        end else begin
            send_high(5);
            send_low(10);
        end
    endtask

    task automatic send_pixel(input logic [23:0] d);
        for (int i = 23; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din = 1'b0;
        for (int j = cyc + 1; (j < cyc + RC + 60) && (j < MAXC); j++) begin
            exp_pv[j]   = 1'b0;
            exp_fd[j]   = 1'b0;
            exp_err[j]  = 1'b0;
            exp_son[j]  = 1'b0;
            exp_soff[j] = 1'b0;
        end
        repeat (4) @(negedge clk);
        rst = 1'b0;
        // Two reset-value synchronizer samples plus this low sample.
        m_locked = 1'b0;
        m_lowrun = 3;
        clr_frame();
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the edge.
    initial begin
        logic        lv_s;
        logic [23:0] lv_pd;
        logic [5:0]  lv_pi;
        logic [6:0]  lv_fp;
        logic        lv_ov;
        bit          e_pv;
        bit          e_fd;
        bit          e_err;
        int          c;
        lv_s = 1'b0; lv_pd = '0; lv_pi = '0; lv_fp = '0; lv_ov = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            c = cyc;
            if (rst || c >= MAXC) begin
                lv_s = 1'b0; lv_pd = '0; lv_pi = '0; lv_fp = '0; lv_ov = 1'b0;
                e_pv = 1'b0; e_fd = 1'b0; e_err = 1'b0;
            end else begin
                if (exp_son[c])  lv_s = 1'b1;
                if (exp_soff[c]) lv_s = 1'b0;
                if (exp_pv[c]) begin
                    lv_pd = exp_pd[c];
                    lv_pi = exp_pi[c];
                end
                if (exp_fd[c]) begin
                    lv_fp = exp_fp[c];
                    lv_ov = exp_ov[c];
                end
                e_pv = exp_pv[c]; e_fd = exp_fd[c]; e_err = exp_err[c];
            end
            chk("pixel_valid", 32'(pixel_valid), 32'(e_pv));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("err", 32'(err), 32'(e_err));
            chk("synced", 32'(synced), 32'(lv_s));
            chk("pixel_data", 32'(pixel_data), 32'(lv_pd));
            chk("pixel_index", 32'(pixel_index), 32'(lv_pi));
            chk("frame_pixels", 32'(frame_pixels), 32'(lv_fp));
            chk("overflow", 32'(overflow), 32'(lv_ov));
            if (pixel_valid === 1'b1) begin
                if (n_pv < 256) cap_pd[n_pv] = pixel_data;
                last_pi = pixel_index;
                n_pv++;
            end
            if (frame_done === 1'b1) begin
                last_fp     = frame_pixels;
                last_ov     = overflow;
                last_fd_err = err;
                n_fd++;
            end
            if (err === 1'b1) n_err++;
        end
    end

    initial begin
        int pv0, fd0, er0, h, l, r;
        logic [23:0] pix;

        do_reset();
        send_low(RC);

        // Single pixel frame.
        pv0 = n_pv; fd0 = n_fd;
        send_pixel(24'h9000FF);
        send_low(RC);
        send_low(20);
        chk("t1_pv_count", 32'(n_pv - pv0), 32'd1);
        chk("t1_pixel", 32'(cap_pd[pv0]), 32'h9000FF);
        chk("t1_index", 32'(last_pi), 32'd0);
        chk("t1_fd_count", 32'(n_fd - fd0), 32'd1);
        chk("t1_fp", 32'(last_fp), 32'd1);
        chk("t1_ov", 32'(last_ov), 32'd0);
        chk("t1_fd_err", 32'(last_fd_err), 32'd0);

        // 65 pixels: last one dropped and overflow reported.
        pv0 = n_pv; fd0 = n_fd;
        for (int p = 0; p < 65; p++) send_pixel(24'hFF00FF);
        send_low(RC);
        send_low(20);
        chk("t2_pv_count", 32'(n_pv - pv0), 32'd64);
        chk("t2_last_index", 32'(last_pi), 32'd63);
        chk("t2_fp", 32'(last_fp), 32'd64);
        chk("t2_ov", 32'(last_ov), 32'd1);

        // 12 bits then a gap: partial pixel.
        pv0 = n_pv; fd0 = n_fd;
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        send_low(RC);
        send_low(20);
        chk("t3_pv_count", 32'(n_pv - pv0), 32'd0);
        chk("t3_fd_count", 32'(n_fd - fd0), 32'd1);
        chk("t3_fp", 32'(last_fp), 32'd0);
        chk("t3_fd_err", 32'(last_fd_err), 32'd1);

        // Threshold on bit 23: width 6 then width 7.
        pv0 = n_pv;
        for (int w = 6; w <= 7; w++) begin
            send_high(w);
            send_low(10);
            for (int i = 0; i < 23; i++) send_bit(1'b0);
        end
        send_low(RC);
        send_low(20);
        chk("t4_pv_count", 32'(n_pv - pv0), 32'd2);
        chk("t4_width6", 32'(cap_pd[pv0]), 32'h000000);
        chk("t4_width7", 32'(cap_pd[pv0 + 1]), 32'h800000);

        // Over-long high mid-frame.
        pv0 = n_pv; fd0 = n_fd; er0 = n_err;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_high(25);
        send_low(10);
        chk("t5_err_count", 32'(n_err - er0), 32'd1);
        chk("t5_synced", 32'(synced), 32'd0);
        send_pixel(24'h123456);
        send_low(10);
        chk("t5_pv_count", 32'(n_pv - pv0), 32'd0);
        chk("t5_fd_count", 32'(n_fd - fd0), 32'd0);
        send_low(RC);
        chk("t5_relock", 32'(synced), 32'd1);

        // Glitches between bits.
        pv0 = n_pv; er0 = n_err;
        pix = 24'hA5C33C;
        for (int i = 23; i >= 0; i--) begin
            send_bit(pix[i]);
            send_high(1);
            send_low(3);
        end
        send_low(RC);
        send_low(20);
        chk("t6_pixel", 32'(cap_pd[pv0]), 32'hA5C33C);
        chk("t6_err_count", 32'(n_err - er0), 32'd0);

        // Reset after 10 bits; decoding needs a fresh gap.
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        do_reset();
        chk("t6_rst_synced", 32'(synced), 32'd0);
        chk("t6_rst_pixel", 32'(pixel_data), 32'd0);
        pv0 = n_pv;
        send_low(50);
        send_pixel(24'h00FF00);
        send_low(10);
        chk("t6_nolock_pv", 32'(n_pv - pv0), 32'd0);
        send_low(RC);
        send_pixel(24'h00FF00);
        send_low(20);
        chk("t6_lock_pv", 32'(n_pv - pv0), 32'd1);

        // Randomized segments.
        for (int s = 0; s < 500; s++) begin
            r = int'($urandom_range(0, 99));
            if (!m_locked && r < 30) begin
                send_low(RC + int'($urandom_range(0, 5)));
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 8)       h = 1;
                else if (r < 9)  h = int'($urandom_range(21, 24));
                else if (r < 50) h = int'($urandom_range(2, 6));
                else             h = int'($urandom_range(7, 20));
                send_high(h);
                r = int'($urandom_range(0, 99));
                if (r < 2)      l = RC - 1;
                else if (r < 5) l = RC + int'($urandom_range(0, 5));
                else            l = int'($urandom_range(1, 30));
                send_low(l);
            end
        end
        send_low(RC + 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
